// File: rtl/nibble_add_seq.sv
// Sequential W-bit adder/subtractor that pushes one nibble per cycle through a
// single 4-bit ripple-carry adder, with a valid/ready request and result handshake.

module rca_n (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        co = c[4];
    end
endmodule

module nibble_add_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ovf,
    output logic         busy
);
    localparam int N  = W / 4;
    localparam int CW = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_s;
    logic       nib_co;

    assign nib_a = a_r[4*cnt +: 4];
    assign nib_b = b_r[4*cnt +: 4];

    rca_n u_rca (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r   <= a;
                        b_r   <= op ? ~b : b;
                        carry <= op ? 1'b1 : ci;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[4*cnt +: 4] <= nib_s;
                    carry         <= nib_co;
                    cnt           <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Top sum bit is nib_s[3]; s[W-1] only lands at this same edge.
                        co    <= nib_co;
                        ovf   <= (a_r[W-1] == b_r[W-1]) && (nib_s[3] != a_r[W-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
endmodule
